// File: rtl/result_tx_sequencer.sv
// Converts a latched ALU result to ASCII decimal and streams it to the UART TX, followed by a terminator byte.
// First tx_start WIDTH+2 cycles after start; each later byte follows its predecessor's tx_done by one cycle.
module result_tx_sequencer #(
    parameter int         WIDTH      = 32,
    parameter int         DIGITS     = 10,
    parameter bit         SIGNED     = 1'b1,
    parameter logic [7:0] TERMINATOR = 8'd32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in_result,
    input  logic             tx_done,
    output logic [7:0]       d_out,
    output logic             tx_start,
    output logic             busy,
    output logic             done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONVERT, S_SIGN, S_SEND,
        S_WAIT_SIGN, S_WAIT, S_TERM, S_WAIT_TERM
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    mag_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic                neg_q;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [7:0]          d_out_q;
    logic                tx_start_q;
    logic                busy_q;
    logic                done_q;

    logic [4*DIGITS-1:0] bcd_d;
    logic [IW-1:0]       msd_d;
    logic [3:0]          digit_d;
    logic                neg_in_d;
    logic [WIDTH-1:0]    mag_in_d;
    logic                tx_ack_d;

    assign neg_in_d = SIGNED && d_in_result[WIDTH-1];
    assign mag_in_d = neg_in_d ? -d_in_result : d_in_result;
    assign digit_d  = bcd_q[{idx_q, 2'b00} +: 4];
    // A tx_done coinciding with our own tx_start belongs to the previous byte's timing, not this one.
    assign tx_ack_d = tx_done && !tx_start_q;

    always_comb begin
        bcd_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        msd_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd_d = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            d_out_q    <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mag_q   <= mag_in_d;
                        neg_q   <= neg_in_d;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (cnt_q != CW'(WIDTH)) begin
                        bcd_q <= {bcd_d[4*DIGITS-2:0], mag_q[WIDTH-1]};
                        mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        idx_q   <= msd_d;
                        state_q <= neg_q ? S_SIGN : S_SEND;
                    end
                end
                S_SIGN: begin
                    d_out_q    <= 8'h2D;
                    tx_start_q <= 1'b1;
                    state_q    <= S_WAIT_SIGN;
                end
                S_SEND: begin
                    d_out_q    <= {4'h3, digit_d};
                    tx_start_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT_SIGN: begin
                    if (tx_ack_d) begin
                        state_q <= S_SEND;
                    end
                end
                S_WAIT: begin
                    if (tx_ack_d) begin
                        if (idx_q == '0) begin
                            state_q <= S_TERM;
                        end else begin
                            idx_q   <= idx_q - IW'(1);
                            state_q <= S_SEND;
                        end
                    end
                end
                S_TERM: begin
                    d_out_q    <= TERMINATOR;
                    tx_start_q <= 1'b1;
                    state_q    <= S_WAIT_TERM;
                end
                S_WAIT_TERM: begin
                    if (tx_ack_d) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign d_out    = d_out_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench: a signed and an unsigned instance, each driven by a UART model that returns tx_done 5 cycles after tx_start.
module tb_result_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] d_in = '0;
    logic [1:0]  start_v = '0;
    logic [1:0]  tx_done_v = '0;
    logic [7:0]  d_out_v [2];
    logic [1:0]  tx_start_v;
    logic [1:0]  busy_v;
    logic [1:0]  done_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    result_tx_sequencer #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b1), .TERMINATOR(8'd32)) u_s (
        .clk(clk), .reset(reset), .start(start_v[0]), .d_in_result(d_in),
        .tx_done(tx_done_v[0]), .d_out(d_out_v[0]), .tx_start(tx_start_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    result_tx_sequencer #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0), .TERMINATOR(8'd32)) u_u (
        .clk(clk), .reset(reset), .start(start_v[1]), .d_in_result(d_in),
        .tx_done(tx_done_v[1]), .d_out(d_out_v[1]), .tx_start(tx_start_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    typedef struct {
        int          sel;
        logic [31:0] val;
        int          inj;
        logic [31:0] inj_val;
        logic [95:0] exp;
        int          len;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_case(input int s, input logic [31:0] val, input int inj,
                            input logic [31:0] inj_val, input logic [95:0] exp,
                            input int explen, input string nm);
        logic [95:0] cap;
        int n, first, pend, dones, done_at, viol, busy_bad;
        logic prev_ts, outst;
        cap = '0; n = 0; first = -1; pend = -1; dones = 0; done_at = -1;
        viol = 0; busy_bad = 0; prev_ts = 1'b0; outst = 1'b0;
        tx_done_v = '0;
        d_in = val;
        start_v[s] = 1'b1;
        step();
        start_v[s] = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            step();
            start_v[s] = 1'b0;
            tx_done_v[s] = 1'b0;
            if (pend == cyc) outst = 1'b0;
            if (tx_start_v[s]) begin
                if (prev_ts || outst) viol++;
                if (first < 0) first = cyc;
                cap = {cap[87:0], d_out_v[s]};
                n++;
                pend = cyc + 5;
                outst = 1'b1;
            end
            prev_ts = tx_start_v[s];
            if (done_v[s]) begin
                dones++;
                if (done_at < 0) done_at = cyc;
                if (busy_v[s]) busy_bad++;
            end else if (done_at < 0 && !busy_v[s]) begin
                busy_bad++;
            end
            if (cyc + 1 == pend) tx_done_v[s] = 1'b1;
            if (cyc == inj) begin
                d_in = inj_val;
                start_v[s] = 1'b1;
            end
            if (done_at >= 0 && cyc >= done_at + 4) break;
        end
        tx_done_v = '0;
        start_v = '0;
        chk({nm, "_first_latency"}, 96'(first), 96'd34);
        chk({nm, "_bytes"}, cap, exp);
        chk({nm, "_count"}, 96'(n), 96'(explen));
        chk({nm, "_done_pulses"}, 96'(dones), 96'd1);
        chk({nm, "_done_timing"}, 96'(done_at), 96'(pend));
        chk({nm, "_handshake"}, 96'(viol), 96'd0);
        chk({nm, "_busy"}, 96'(busy_bad), 96'd0);
    endtask

    initial begin
        int first;
        int idle_bad;
        logic [7:0] d_before;

        vecs[0] = '{0, 32'd65,         -1, 32'd0, "65 ",          3};
        vecs[1] = '{0, 32'd0,          -1, 32'd0, "0 ",           2};
        vecs[2] = '{0, 32'hFFFFFFF9,   -1, 32'd0, "-7 ",          3};
        vecs[3] = '{1, 32'hFFFFFFF9,   -1, 32'd0, "4294967289 ",  11};
        vecs[4] = '{0, 32'h80000000,   -1, 32'd0, "-2147483648 ", 12};
        vecs[5] = '{0, 32'd1000000000, -1, 32'd0, "1000000000 ",  11};
        vecs[6] = '{0, 32'd12,         36, 32'd9, "12 ",          3};
        vecs[7] = '{0, 32'd100,        -1, 32'd0, "100 ",         4};
        vecs[8] = '{1, 32'h80000000,   -1, 32'd0, "2147483648 ",  11};
        vecs[9] = '{0, 32'h7FFFFFFF,   -1, 32'd0, "2147483647 ",  11};

        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_state_s", {84'd0, d_out_v[0], tx_start_v[0], busy_v[0], done_v[0]}, 96'd0);
        chk("reset_state_u", {84'd0, d_out_v[1], tx_start_v[1], busy_v[1], done_v[1]}, 96'd0);

        for (int i = 0; i < 10; i++) begin
            run_case(vecs[i].sel, vecs[i].val, vecs[i].inj, vecs[i].inj_val,
                     vecs[i].exp, vecs[i].len, $sformatf("v%0d", i));
            step();
        end

        // tx_done while idle must not provoke any byte
        idle_bad = 0;
        tx_done_v[0] = 1'b1;
        step();
        tx_done_v[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (tx_start_v[0] || busy_v[0] || done_v[0]) idle_bad++;
            step();
        end
        chk("idle_tx_done", 96'(idle_bad), 96'd0);

        // reset while the first digit of 345 is in flight
        d_in = 32'd345;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        first = -1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (tx_start_v[0]) begin
                first = c;
                break;
            end
        end
        d_before = d_out_v[0];
        chk("rst_pre_first", 96'(first), 96'd34);
        chk("rst_pre_byte", 96'(d_before), 96'h33);
        reset = 1'b1;
        #1;
        chk("rst_tx_start", 96'(tx_start_v[0]), 96'd0);
        chk("rst_busy", 96'(busy_v[0]), 96'd0);
        chk("rst_d_out", 96'(d_out_v[0]), 96'd0);
        step();
        reset = 1'b0;
        step();
        run_case(0, 32'd8, -1, 32'd0, "8 ", 2, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
